// File: rtl/fft16_pkg.sv
// Shared constants, FSM states and helpers for the 16-point FFT memory sequencer.
package fft16_pkg;

    localparam int N     = 16;
    localparam int LOG2N = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WAIT,
        S_UNLOAD
    } state_e;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft16_addr_gen.sv
// Maps (stage, butterfly index) to the radix-2 DIT operand pair and twiddle index.
module fft16_addr_gen (
    input  logic [1:0] s_i,
    input  logic [2:0] k_i,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic [2:0] tw_o
);

    logic [3:0] k4;
    logic [3:0] span;
    logic [3:0] mask;

    always_comb begin
        k4   = {1'b0, k_i};
        span = 4'd1 << s_i;
        mask = span - 4'd1;
        a_o  = ((k4 >> s_i) << ({1'b0, s_i} + 3'd1)) | (k4 & mask);
        b_o  = a_o + span;
        tw_o = 3'((k4 & mask) << (3'd3 - {1'b0, s_i}));
    end

endmodule

// File: rtl/fft16_mem_ctrl.sv
// Frame sequencer: bit-reversed load, 4x8 butterfly issue with delayed write-back, unload.
module fft16_mem_ctrl
    import fft16_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BF_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [3:0]        rd_addr_1,
    output logic [3:0]        rd_addr_2,
    input  logic [DATA_W-1:0] rd_data_1,
    output logic              rd_valid,
    output logic [2:0]        tw_idx,
    input  logic [DATA_W-1:0] bf_data_1,
    input  logic [DATA_W-1:0] bf_data_2,
    output logic [3:0]        wr_addr_1,
    output logic [3:0]        wr_addr_2,
    output logic [DATA_W-1:0] wr_data_1,
    output logic [DATA_W-1:0] wr_data_2,
    output logic              wr_en_1,
    output logic              wr_en_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int AW = 4 * BF_LAT;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        stg_q, stg_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic              done_q, done_d;
    logic [BF_LAT-1:0] dv_q;
    logic [AW-1:0]     da_q;
    logic [AW-1:0]     db_q;

    logic [3:0] ag_a, ag_b;
    logic [2:0] ag_tw;
    logic       issue;
    logic       wb_v;
    logic [3:0] wb_a, wb_b;

    fft16_addr_gen u_addr_gen (
        .s_i  (stg_q),
        .k_i  (cnt_q[2:0]),
        .a_o  (ag_a),
        .b_o  (ag_b),
        .tw_o (ag_tw)
    );

    assign issue = (state_q == S_CALC);
    assign wb_v  = dv_q[BF_LAT-1];
    assign wb_a  = da_q[AW-1 -: 4];
    assign wb_b  = db_q[AW-1 -: 4];
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            dv_q    <= '0;
            da_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            // Operand addresses ride alongside the butterfly pipeline.
            dv_q    <= BF_LAT'({dv_q, issue});
            da_q    <= AW'({da_q, ag_a});
            db_q    <= AW'({db_q, ag_b});
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stg_d     = stg_q;
        wcnt_d    = wcnt_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        rd_addr_1 = '0;
        rd_addr_2 = '0;
        rd_valid  = 1'b0;
        tw_idx    = '0;
        out_valid = 1'b0;
        out_data  = '0;
        wr_en_1   = wb_v;
        wr_en_2   = wb_v;
        wr_addr_1 = wb_v ? wb_a : 4'd0;
        wr_addr_2 = wb_v ? wb_b : 4'd0;
        wr_data_1 = wb_v ? bf_data_1 : '0;
        wr_data_2 = wb_v ? bf_data_2 : '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                wr_addr_1 = bitrev4(cnt_q);
                if (in_valid) begin
                    wr_en_1   = 1'b1;
                    wr_data_1 = in_data;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'(N - 1)) begin
                        state_d = S_CALC;
                        stg_d   = '0;
                    end
                end
            end
            S_CALC: begin
                rd_valid  = 1'b1;
                rd_addr_1 = ag_a;
                rd_addr_2 = ag_b;
                tw_idx    = ag_tw;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q[2:0] == 3'd7) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'(BF_LAT - 1)) begin
                    wcnt_d = '0;
                    if (stg_q == 2'(LOG2N - 1)) begin
                        state_d = S_UNLOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_CALC;
                        stg_d   = stg_q + 2'd1;
                    end
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                rd_addr_1 = cnt_q;
                out_data  = rd_data_1;
                if (out_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(N - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
